// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the core and the mul/div unit.
// The core drives the request; the unit returns the rd write strobe.
interface riscv_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             kill;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [4:0]       rd_index_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rd;
  logic [4:0]       rd_index;
  logic             enable_write_rd;

  modport master (
    output start, kill, funct3,
    output rs1, rs2, rd_index_in,
    input  busy, done, rd,
    input  rd_index, enable_write_rd
  );

  modport slave (
    input  start, kill, funct3,
    input  rs1, rs2, rd_index_in,
    output busy, done, rd,
    output rd_index, enable_write_rd
  );
endinterface

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, sign fixup at the end.
module riscv_muldiv #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input logic           clock,
  input logic           reset,
  riscv_muldiv_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       counter;
  logic [2:0]       op;
  logic             neg;
  logic [WIDTH-1:0] bmag;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] rd_q;
  logic [4:0]       rd_idx_q;

  logic             accept;
  logic             a_sgn, b_sgn;
  logic             a_neg, b_neg;
  logic             b_zero, ovf, early;
  logic             neg_in;
  logic [WIDTH-1:0] amag_in, bmag_in;
  logic [WIDTH-1:0] early_res;
  logic [WIDTH-1:0] smin;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh, div_diff;
  logic [W2-1:0]    acc_step;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] result;

  assign smin   = {1'b1, {(WIDTH - 1){1'b0}}};
  assign accept = (state == IDLE) && bus.start && !bus.kill;

  // Decode the incoming request: operand magnitudes, result sign, early-out.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (bus.funct3)
      3'b001:  begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:  a_sgn = 1'b1;
      3'b100:  begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b110:  begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default: ;
    endcase
    a_neg   = a_sgn && bus.rs1[WIDTH-1];
    b_neg   = b_sgn && bus.rs2[WIDTH-1];
    amag_in = a_neg ? -bus.rs1 : bus.rs1;
    bmag_in = b_neg ? -bus.rs2 : bus.rs2;
    b_zero  = (bus.rs2 == '0);
    ovf     = bus.funct3[2] && !bus.funct3[0] &&
              (bus.rs1 == smin) && (bus.rs2 == '1);
    early   = EARLY_OUT && bus.funct3[2] && (b_zero || ovf);
    if (!bus.funct3[2])
      neg_in = a_neg ^ b_neg;
    else if (bus.funct3[1])
      neg_in = a_neg;
    else
      neg_in = (a_neg ^ b_neg) && !b_zero;
    if (b_zero)
      early_res = bus.funct3[1] ? bus.rs1 : '1;
    else
      early_res = bus.funct3[1] ? '0 : smin;
  end

  // One multiply or divide iteration plus the final sign fixup.
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} +
               (acc[0] ? {1'b0, bmag} : '0);
    div_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, bmag};
    if (!op[2])
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod = neg ? -acc_step : acc_step;
    quo  = acc_step[WIDTH-1:0];
    rem  = acc_step[W2-1:WIDTH];
    if (!op[2])
      result = (op[1:0] == 2'b00) ? prod[WIDTH-1:0]
                                  : prod[W2-1:WIDTH];
    else if (op[1])
      result = neg ? -rem : rem;
    else
      result = neg ? -quo : quo;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start/early-out from IDLE, kill or finish in CALC.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = early ? DONE : CALC;
      CALC: begin
        if (bus.kill)
          state_nxt = IDLE;
        else if (counter == 5'd31)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      op       <= '0;
      neg      <= 1'b0;
      bmag     <= '0;
      acc      <= '0;
      rd_q     <= '0;
      rd_idx_q <= '0;
    end else if (accept) begin
      counter  <= '0;
      op       <= bus.funct3;
      neg      <= neg_in;
      bmag     <= bmag_in;
      acc      <= {{WIDTH{1'b0}}, amag_in};
      rd_idx_q <= bus.rd_index_in;
      if (early) rd_q <= early_res;
    end else if (state == CALC && !bus.kill) begin
      acc     <= acc_step;
      counter <= counter + 5'd1;
      if (counter == 5'd31) rd_q <= result;
    end
  end

  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.rd              = rd_q;
  assign bus.rd_index        = rd_idx_q;
  assign bus.enable_write_rd = bus.done && (rd_idx_q != 5'd0);
endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed-vector bench for riscv_muldiv.
// Inputs change and outputs are sampled on the falling edge.
module tb_riscv_muldiv;
  logic clock;
  logic reset;
  int   checks;
  int   passed;

  riscv_muldiv_if bus ();

  riscv_muldiv dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one op; lat = N means done seen in the cycle
  // ending at the Nth rising edge after the start edge.
  task automatic run_op(
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  idx,
    output int          lat,
    output logic [31:0] res,
    output logic        ewr,
    output logic [4:0]  ridx,
    output logic        after
  );
    @(negedge clock);
    bus.start       = 1'b1;
    bus.funct3      = f3;
    bus.rs1         = a;
    bus.rs2         = b;
    bus.rd_index_in = idx;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    res  = bus.rd;
    ewr  = bus.enable_write_rd;
    ridx = bus.rd_index;
    @(negedge clock);
    after = bus.done | bus.enable_write_rd;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.enable_write_rd} !== 3'b000)
      $display("FAIL reset_flags got %b want 000",
               {bus.busy, bus.done, bus.enable_write_rd});
    else passed++;
    checks++;
    if (bus.rd !== 32'h0 || bus.rd_index !== 5'd0)
      $display("FAIL reset_rd got %h/%0d want 0/0",
               bus.rd, bus.rd_index);
    else passed++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL reset_idle busy got %b want 0", bus.busy);
    else passed++;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] r; logic w, af; logic [4:0] ix;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5,
           lat, r, w, ix, af);
    checks++;
    if (lat !== 33 || r !== 32'hFFFF_FFEB)
      $display("FAIL mul got lat %0d rd %h want 33 ffffffeb",
               lat, r);
    else passed++;
    checks++;
    if (w !== 1'b1 || ix !== 5'd5 || af !== 1'b0)
      $display("FAIL mul_wr got ewr %b idx %0d after %b want 1 5 0",
               w, ix, af);
    else passed++;
  endtask

  task automatic test_mulh();
    logic [2:0]  f3 [3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] a  [3] = '{32'h8000_0000, '1, '1};
    logic [31:0] b  [3] = '{32'h8000_0000, '1, '1};
    logic [31:0] e  [3] = '{32'h4000_0000, 32'hFFFF_FFFE, '1};
    int lat; logic [31:0] r; logic w, af; logic [4:0] ix;
    for (int i = 0; i < 3; i++) begin
      run_op(f3[i], a[i], b[i], 5'd1, lat, r, w, ix, af);
      checks++;
      if (lat !== 33 || r !== e[i])
        $display("FAIL mulh%0d got lat %0d rd %h want 33 %h",
                 i, lat, r, e[i]);
      else passed++;
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, '1, 32'd7};
    logic [31:0] b  [4] = '{32'd2, 32'd2, 32'd2, 32'd3};
    logic [31:0] e  [4] = '{32'hFFFF_FFFD, '1, 32'h7FFF_FFFF, 32'd1};
    int lat; logic [31:0] r; logic w, af; logic [4:0] ix;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], 5'd2, lat, r, w, ix, af);
      checks++;
      if (lat !== 33 || r !== e[i])
        $display("FAIL div%0d got lat %0d rd %h want 33 %h",
                 i, lat, r, e[i]);
      else passed++;
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [5] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101};
    logic [31:0] a  [5] = '{32'd5, 32'd5, 32'h8000_0000,
                            32'h8000_0000, 32'd9};
    logic [31:0] b  [5] = '{32'd0, 32'd0, '1, '1, 32'd0};
    logic [31:0] e  [5] = '{'1, 32'd5, 32'h8000_0000, 32'd0, '1};
    int lat; logic [31:0] r; logic w, af; logic [4:0] ix;
    for (int i = 0; i < 5; i++) begin
      run_op(f3[i], a[i], b[i], 5'd6, lat, r, w, ix, af);
      checks++;
      if (lat !== 1 || r !== e[i] || w !== 1'b1)
        $display("FAIL spec%0d got lat %0d rd %h ewr %b want 1 %h 1",
                 i, lat, r, w, e[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit seen;
    @(negedge clock);
    bus.start = 1'b1; bus.funct3 = 3'b101;
    bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.rd_index_in = 5'd3;
    @(negedge clock);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.funct3 = 3'b000;
        bus.rs1 = 32'd2; bus.rs2 = 32'd3; bus.rd_index_in = 5'd9;
      end else bus.start = 1'b0;
      @(negedge clock);
      lat++;
    end
    bus.start = 1'b0;
    checks++;
    if (lat !== 33 || bus.rd !== 32'd14 || bus.rd_index !== 5'd3)
      $display("FAIL busy_start got lat %0d rd %h idx %0d want 33 e 3",
               lat, bus.rd, bus.rd_index);
    else passed++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.busy || bus.done) seen = 1;
    end
    checks++;
    if (seen !== 1'b0)
      $display("FAIL no_queue got activity %b want 0", seen);
    else passed++;
  endtask

  task automatic test_kill();
    int lat; bit seen; logic [31:0] r; logic w, af; logic [4:0] ix;
    @(negedge clock);
    bus.start = 1'b1; bus.kill = 1'b1; bus.funct3 = 3'b000;
    bus.rs1 = 32'd3; bus.rs2 = 32'd3; bus.rd_index_in = 5'd4;
    @(negedge clock);
    bus.start = 1'b0; bus.kill = 1'b0;
    checks++;
    if (bus.busy !== 1'b0)
      $display("FAIL start_kill busy got %b want 0", bus.busy);
    else passed++;
    bus.start = 1'b1; bus.rs1 = 32'd5; bus.rs2 = 32'd6;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 1; i < 11; i++) @(negedge clock);
    bus.kill = 1'b1;
    @(negedge clock);
    bus.kill = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL kill got busy %b done %b want 0 0",
               bus.busy, bus.done);
    else passed++;
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      if (bus.done || bus.enable_write_rd) seen = 1;
      @(negedge clock);
    end
    checks++;
    if (seen !== 1'b0)
      $display("FAIL kill_nowrite got write %b want 0", seen);
    else passed++;
    run_op(3'b111, 32'd7, 32'd3, 5'd8, lat, r, w, ix, af);
    checks++;
    if (lat !== 33 || r !== 32'd1 || ix !== 5'd8)
      $display("FAIL after_kill got lat %0d rd %h idx %0d want 33 1 8",
               lat, r, ix);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] r; logic w, af; logic [4:0] ix;
    @(negedge clock);
    bus.start = 1'b1; bus.funct3 = 3'b000;
    bus.rs1 = 32'd9; bus.rs2 = 32'd9; bus.rd_index_in = 5'd7;
    @(negedge clock);
    bus.start = 1'b0;
    for (int i = 1; i < 21; i++) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.enable_write_rd} !== 3'b000)
      $display("FAIL reset_mid got %b want 000",
               {bus.busy, bus.done, bus.enable_write_rd});
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    run_op(3'b000, 32'd3, 32'd4, 5'd0, lat, r, w, ix, af);
    checks++;
    if (lat !== 33 || r !== 32'd12 || w !== 1'b0)
      $display("FAIL rd0 got lat %0d rd %h ewr %b want 33 c 0",
               lat, r, w);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = 3'b000;
    bus.rs1 = '0; bus.rs2 = '0; bus.rd_index_in = '0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
